// File: rtl/sample_loader.sv
// Sample batch loader: fills a DEPTH-entry buffer from a valid/ready
// stream, then hands the frozen batch to a mean unit with start/done.
// Ports: clk, rst (async, active high), in_data/in_valid/in_ready
// (sample stream), mem (batch buffer, indices 1..DEPTH), start,
// mean_ready, mean_done (mean unit handshake), count, batches.
module sample_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mem [1:DEPTH],
    output logic             start,
    input  logic             mean_ready,
    input  logic             mean_done,
    output logic [5:0]       count,
    output logic [7:0]       batches
);

    typedef enum logic [1:0] {
        FILL,
        ARM,
        START,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic [7:0]       batches_q, batches_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] mem_q [1:DEPTH];
    logic [WIDTH-1:0] mem_d [1:DEPTH];
    logic             xfer;

    // Deasserted during reset so nothing is accepted while state is forced.
    assign in_ready = (state_q == FILL) && !rst;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        batches_d = batches_q;
        mem_d     = mem_q;
        unique case (state_q)
            FILL: begin
                if (xfer) begin
                    count_d = count_q + 6'd1;
                    if (count_q == 6'(DEPTH - 1)) begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                if (mean_ready) begin
                    state_d = START;
                end
            end
            // Hold start until the mean unit drops ready (accepted).
            START: begin
                if (!mean_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mean_done) begin
                    state_d   = FILL;
                    count_d   = '0;
                    batches_d = batches_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
        // Writes only happen in FILL, so the buffer is frozen otherwise.
        for (int i = 1; i <= DEPTH; i++) begin
            if (xfer && (count_q == 6'(i - 1))) begin
                mem_d[i] = in_data;
            end
        end
        start_d = (state_d == START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            count_q   <= '0;
            batches_q <= '0;
            start_q   <= 1'b0;
            for (int i = 1; i <= DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            batches_q <= batches_d;
            start_q   <= start_d;
            mem_q     <= mem_d;
        end
    end

    assign mem     = mem_q;
    assign start   = start_q;
    assign count   = count_q;
    assign batches = batches_q;

endmodule

// File: tb/tb_sample_loader.sv
// Bench for sample_loader: expected samples are queued as they are
// driven and compared against mem when the batch start appears.
module tb_sample_loader;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem [1:32];
    logic       start;
    logic       mean_ready;
    logic       mean_done;
    logic [5:0] count;
    logic [7:0] batches;

    int         n_chk;
    int         n_pass;
    logic [7:0] exp_q [$];
    int         exp_batches;

    sample_loader #(.WIDTH(8), .DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem       (mem),
        .start     (start),
        .mean_ready(mean_ready),
        .mean_done (mean_done),
        .count     (count),
        .batches   (batches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            chk("push_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(d);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_batch();
        logic [7:0] e;
        chk("q_size", exp_q.size(), 32'd32);
        for (int i = 1; i <= 32; i++) begin
            if (exp_q.size() == 0) begin
                chk("q_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(e));
            end
        end
        exp_q.delete();
    endtask

    task automatic finish_batch();
        mean_ready = 1'b0;
        tick();
        chk("wd_start", 32'(start), 32'd0);
        mean_done = 1'b1;
        tick();
        mean_done = 1'b0;
        exp_batches = (exp_batches + 1) % 256;
        chk("done_count", 32'(count), 32'd0);
        chk("batches", 32'(batches), 32'(exp_batches));
    endtask

    task automatic toggle_batch();
        int   guard;
        int   writes;
        logic v;
        guard      = 0;
        writes     = 0;
        v          = 1'b0;
        mean_ready = 1'b1;
        while (!start && guard < 300) begin
            v        = ~v;
            in_valid = v;
            in_data  = 8'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                writes++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 300) begin
            chk("tog_timeout", 32'd0, 32'd1);
        end
        chk("tog_writes", 32'(writes), 32'd32);
        chk("tog_count", 32'(count), 32'd32);
        check_batch();
        finish_batch();
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        exp_batches = 0;
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        mean_ready  = 1'b0;
        mean_done   = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_batches", 32'(batches), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_mem1", 32'(mem[1]), 32'd0);
        chk("rst_mem32", 32'(mem[32]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);

        // Back-to-back fill with mean unit already ready.
        mean_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
        end
        chk("fill_count", 32'(count), 32'd32);
        chk("fill_start0", 32'(start), 32'd0);
        chk("fill_ready0", 32'(in_ready), 32'd0);
        tick();
        chk("start_rise", 32'(start), 32'd1);
        check_batch();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("start_hold", 32'(start), 32'd1);
        end
        mean_ready = 1'b0;
        tick();
        chk("start_fall", 32'(start), 32'd0);
        chk("wd_ready", 32'(in_ready), 32'd0);

        // mean_done with a pending sample: no write on that edge.
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        mean_done = 1'b1;
        tick();
        mean_done   = 1'b0;
        exp_batches = 1;
        chk("ret_count", 32'(count), 32'd0);
        chk("ret_batches", 32'(batches), 32'd1);
        chk("ret_nowrite", 32'(mem[1]), 32'd0);
        chk("ret_ready", 32'(in_ready), 32'd1);
        push(8'hAA);
        chk("new_mem1", 32'(mem[1]), 32'hAA);
        chk("new_count", 32'(count), 32'd1);
        for (int i = 1; i < 32; i++) begin
            push(8'(i * 7 + 3));
        end

        // Stall in ARM; stray mean_done must be ignored.
        mean_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arm_start", 32'(start), 32'd0);
            chk("arm_ready", 32'(in_ready), 32'd0);
            chk("arm_count", 32'(count), 32'd32);
        end
        mean_done  = 1'b0;
        mean_ready = 1'b1;
        tick();
        chk("arm_go", 32'(start), 32'd1);
        check_batch();
        finish_batch();

        // Reset mid-batch discards everything.
        mean_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'(i + 100));
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_batches = 0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_batches", 32'(batches), 32'd0);
        chk("mrst_start", 32'(start), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("mrst_mem[%0d]", i), 32'(mem[i]), 32'd0);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_rel", 32'(in_ready), 32'd1);
        tick();
        chk("mrst_nostart", 32'(start), 32'd0);

        // 256 batches with half-rate input: counter wraps to zero.
        for (int b = 0; b < 256; b++) begin
            toggle_batch();
        end
        chk("wrap", 32'(batches), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
